// File: rtl/ooo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ooo_pkg
//  Purpose  : Shared types and helpers for the out-of-order core: ROB entry
//             layout, index-width helper, default data/register widths.
//  Revision : 1.0  initial release
// ============================================================================
package ooo_pkg;

  localparam int ROB_DATA_W = 16;
  localparam int ROB_REG_W  = 4;

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic                  halt;
    logic                  mispred;
    logic [ROB_REG_W-1:0]  rt;
    logic [ROB_DATA_W-1:0] value;
  } rob_entry_t;

  // Index width for a table of 'depth' entries (at least one bit)
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_n_if.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer_n_if
//  Purpose  : Allocation, writeback, commit and status bundle of the ROB.
//             master = pipeline side, slave = reorder buffer.
//  Revision : 1.0  initial release
// ============================================================================
interface reorder_buffer_n_if
  import ooo_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ALLOC_W  = 4,
  parameter int COMMIT_W = 4,
  parameter int CDB_W    = 4,
  parameter int DATA_W   = ROB_DATA_W,
  parameter int REG_W    = ROB_REG_W
);
  localparam int IW = idx_w(DEPTH);

  logic [ALLOC_W-1:0]          alloc_valid;
  logic [ALLOC_W*REG_W-1:0]    alloc_rt;
  logic [ALLOC_W-1:0]          alloc_halt;
  logic [ALLOC_W*IW-1:0]       alloc_idx;
  logic [IW:0]                 free_slots;
  logic [CDB_W-1:0]            cdb_valid;
  logic [CDB_W*IW-1:0]         cdb_idx;
  logic [CDB_W*DATA_W-1:0]     cdb_value;
  logic [CDB_W-1:0]            cdb_mispred;
  logic [DEPTH-1:0]            ent_ready;
  logic [DEPTH*DATA_W-1:0]     ent_value;
  logic [COMMIT_W-1:0]         cmt_we;
  logic [COMMIT_W*REG_W-1:0]   cmt_rt;
  logic [COMMIT_W*DATA_W-1:0]  cmt_data;
  logic [COMMIT_W*IW-1:0]      cmt_idx;
  logic                        flush;
  logic [DATA_W-1:0]           redirect_pc;
  logic                        halted;
  logic [IW-1:0]               head;

  modport master (
    output alloc_valid, alloc_rt, alloc_halt,
    output cdb_valid, cdb_idx, cdb_value, cdb_mispred,
    input  alloc_idx, free_slots, ent_ready, ent_value,
    input  cmt_we, cmt_rt, cmt_data, cmt_idx, flush, redirect_pc, halted, head
  );

  modport slave (
    input  alloc_valid, alloc_rt, alloc_halt,
    input  cdb_valid, cdb_idx, cdb_value, cdb_mispred,
    output alloc_idx, free_slots, ent_ready, ent_value,
    output cmt_we, cmt_rt, cmt_data, cmt_idx, flush, redirect_pc, halted, head
  );

endinterface
`default_nettype wire

// File: rtl/rob_commit_select.sv
`default_nettype none
// ============================================================================
//  Module   : rob_commit_select
//  Purpose  : Prefix scan over the COMMIT_W oldest ROB entries. A lane retires
//             only if every older lane retires; a mispredicted branch may
//             retire but closes the scan; a halt at the head blocks all lanes.
//  Revision : 1.0  initial release
// ============================================================================
module rob_commit_select
  import ooo_pkg::*;
#(
  parameter int COMMIT_W = 4,
  parameter int CNT_W    = 5,
  parameter int LANE_W   = 2
) (
  input  logic [COMMIT_W-1:0] valid,
  input  logic [COMMIT_W-1:0] ready,
  input  logic [COMMIT_W-1:0] halt,
  input  logic [COMMIT_W-1:0] mispred,
  output logic [COMMIT_W-1:0] we,
  output logic [CNT_W-1:0]    cnt,
  output logic                flush,
  output logic [LANE_W-1:0]   flush_lane,
  output logic                halt_head
);

  logic scan_open;

  // Walk lanes oldest first; the first ineligible or mispredicted lane ends the run
  always_comb begin
    we         = '0;
    cnt        = '0;
    flush      = 1'b0;
    flush_lane = '0;
    scan_open  = 1'b1;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (scan_open && valid[k] && ready[k] && !halt[k]) begin
        we[k] = 1'b1;
        cnt   = cnt + CNT_W'(1);
        if (mispred[k]) begin
          flush      = 1'b1;
          flush_lane = LANE_W'(k);
          scan_open  = 1'b0;
        end
      end else begin
        scan_open = 1'b0;
      end
    end
    halt_head = valid[0] & halt[0];
  end

endmodule
`default_nettype wire

// File: rtl/reorder_buffer_n.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer_n
//  Purpose  : Parametrised reorder buffer: in-order allocate (ALLOC_W/cycle),
//             CDB writeback (CDB_W lanes), in-order retire (COMMIT_W/cycle),
//             mispredict flush, sticky halt and free-slot reporting.
//  Config   : ROB_CDB_BYPASS_EN - operand view includes same-cycle CDB writes
//  Revision : 1.0  initial release
// ============================================================================
module reorder_buffer_n
  import ooo_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ALLOC_W  = 4,
  parameter int COMMIT_W = 4,
  parameter int CDB_W    = 4,
  parameter int DATA_W   = ROB_DATA_W,
  parameter int REG_W    = ROB_REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  reorder_buffer_n_if.slave bus
);
  localparam int IW = idx_w(DEPTH);
  localparam int CW = IW + 1;
  localparam int LW = idx_w(COMMIT_W);

  rob_entry_t          ent [DEPTH];
  logic [IW-1:0]       head_ptr;
  logic [IW-1:0]       tail_ptr;
  logic [CW-1:0]       count;
  logic                halt_seen;

  rob_entry_t          win [COMMIT_W];
  logic [COMMIT_W-1:0] win_valid, win_ready, win_halt, win_mispred, cmt_sel;
  logic [CW-1:0]       cmt_cnt, acc_cnt, free_cnt;
  logic [LW-1:0]       flush_lane;
  logic                flush_sel, halt_head, halted_now, wb_en;
  logic [ALLOC_W-1:0]  acc;

  for (genvar k = 0; k < COMMIT_W; k++) begin : g_win
    assign win[k]         = ent[head_ptr + IW'(k)];
    assign win_valid[k]   = win[k].valid;
    assign win_ready[k]   = win[k].ready;
    assign win_halt[k]    = win[k].halt;
    assign win_mispred[k] = win[k].mispred;
  end

  rob_commit_select #(
    .COMMIT_W (COMMIT_W),
    .CNT_W    (CW),
    .LANE_W   (LW)
  ) u_sel (
    .valid      (win_valid),
    .ready      (win_ready),
    .halt       (win_halt),
    .mispred    (win_mispred),
    .we         (cmt_sel),
    .cnt        (cmt_cnt),
    .flush      (flush_sel),
    .flush_lane (flush_lane),
    .halt_head  (halt_head)
  );

  assign free_cnt   = CW'(DEPTH) - count;
  assign halted_now = halt_seen | halt_head;
  // Writebacks are dropped in a flush cycle and once the ROB is frozen
  assign wb_en      = !flush_sel && !halted_now;

  // Accept the leading lanes that fit; anything beyond free space is dropped
  always_comb begin
    acc     = '0;
    acc_cnt = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      if (bus.alloc_valid[i] && (CW'(i) < free_cnt) && !halted_now) begin
        acc[i]  = 1'b1;
        acc_cnt = acc_cnt + CW'(1);
      end
    end
  end

  // Entry table, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_ptr  <= '0;
      tail_ptr  <= '0;
      count     <= '0;
      halt_seen <= 1'b0;
      for (int e = 0; e < DEPTH; e++) ent[e] <= '0;
    end else begin
      halt_seen <= halt_seen | halt_head;
      head_ptr  <= head_ptr + IW'(cmt_cnt);
      if (flush_sel) begin
        for (int e = 0; e < DEPTH; e++) ent[e].valid <= 1'b0;
        tail_ptr <= head_ptr + IW'(cmt_cnt);
        count    <= '0;
      end else begin
        // Highest lane first so the lowest lane's write lands last and wins
        if (wb_en) begin
          for (int l = CDB_W - 1; l >= 0; l--) begin
            if (bus.cdb_valid[l] && ent[bus.cdb_idx[l*IW +: IW]].valid) begin
              ent[bus.cdb_idx[l*IW +: IW]].ready   <= 1'b1;
              ent[bus.cdb_idx[l*IW +: IW]].value   <= bus.cdb_value[l*DATA_W +: DATA_W];
              ent[bus.cdb_idx[l*IW +: IW]].mispred <= bus.cdb_mispred[l];
            end
          end
        end
        for (int i = 0; i < ALLOC_W; i++) begin
          if (acc[i]) begin
            ent[tail_ptr + IW'(i)] <= '{valid: 1'b1, ready: bus.alloc_halt[i],
                                       halt: bus.alloc_halt[i], mispred: 1'b0,
                                       rt: bus.alloc_rt[i*REG_W +: REG_W], value: '0};
          end
        end
        for (int k = 0; k < COMMIT_W; k++) begin
          if (cmt_sel[k]) ent[head_ptr + IW'(k)].valid <= 1'b0;
        end
        tail_ptr <= tail_ptr + IW'(acc_cnt);
        count    <= count + acc_cnt - cmt_cnt;
      end
    end
  end

  // Upstream must honour free_slots and present a thermometer allocate mask
  always_ff @(posedge clk) begin
    if (rst_n && !halted_now) begin
      assert ($countones(bus.alloc_valid) <= int'(free_cnt));
      assert ((bus.alloc_valid & (bus.alloc_valid + ALLOC_W'(1))) == '0);
    end
  end

  // Retire-port drive; idle lanes read as zero
  always_comb begin
    bus.cmt_we   = cmt_sel;
    bus.cmt_rt   = '0;
    bus.cmt_data = '0;
    bus.cmt_idx  = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (cmt_sel[k]) begin
        bus.cmt_rt[k*REG_W +: REG_W]    = win[k].rt;
        bus.cmt_data[k*DATA_W +: DATA_W] = win[k].value;
        bus.cmt_idx[k*IW +: IW]          = head_ptr + IW'(k);
      end
    end
  end

  // Allocation indices and status outputs
  always_comb begin
    bus.alloc_idx = '0;
    for (int i = 0; i < ALLOC_W; i++) bus.alloc_idx[i*IW +: IW] = tail_ptr + IW'(i);
    bus.free_slots  = free_cnt;
    bus.flush       = flush_sel;
    bus.redirect_pc = flush_sel ? win[flush_lane].value : '0;
    bus.halted      = halted_now;
    bus.head        = head_ptr;
  end

  // Operand lookup view, optionally including this cycle's CDB writes
  always_comb begin
    bus.ent_ready = '0;
    bus.ent_value = '0;
    for (int e = 0; e < DEPTH; e++) begin
      logic              rdy;
      logic [DATA_W-1:0] val;
      rdy = ent[e].valid & ent[e].ready;
      val = ent[e].value;
`ifdef ROB_CDB_BYPASS_EN
      for (int l = CDB_W - 1; l >= 0; l--) begin
        if (wb_en && bus.cdb_valid[l] && ent[e].valid && (bus.cdb_idx[l*IW +: IW] == IW'(e))) begin
          rdy = 1'b1;
          val = bus.cdb_value[l*DATA_W +: DATA_W];
        end
      end
`endif
      bus.ent_ready[e]                  = rdy;
      bus.ent_value[e*DATA_W +: DATA_W] = rdy ? val : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reorder_buffer_n
//  Purpose  : Directed, table-driven bench for reorder_buffer_n (DEPTH=16).
//             Each row drives one cycle and lists the outputs expected in
//             that cycle before the clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reorder_buffer_n;

`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  reorder_buffer_n_if #(.DEPTH(16), .ALLOC_W(4), .COMMIT_W(4), .CDB_W(4),
                        .DATA_W(16), .REG_W(4)) bus ();

  reorder_buffer_n #(.DEPTH(16), .ALLOC_W(4), .COMMIT_W(4), .CDB_W(4),
                     .DATA_W(16), .REG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  av;   logic [15:0] art;  logic [3:0] ah;
    logic [3:0]  cv;   logic [15:0] cidx; logic [63:0] cval; logic [3:0] cmp;
    logic [3:0]  we;   logic [63:0] data; logic [15:0] rt;   logic [15:0] ci;
    logic [4:0]  free; logic [3:0] head;  logic [15:0] aidx;
    logic        fl;   logic [15:0] pc;   logic hlt;
    logic        chk;  logic [15:0] rdy;
  } vec_t;

  vec_t tbl[$];

  typedef longint unsigned u64;

  function automatic vec_t row(u64 rst, u64 av, u64 art, u64 ah, u64 cv, u64 cidx, u64 cval, u64 cmp,
                               u64 we, u64 data, u64 rt, u64 ci, u64 free, u64 head, u64 aidx,
                               u64 fl, u64 pc, u64 hlt, u64 chk, u64 rdy);
    vec_t v;
    v.rst = 1'(rst); v.av = 4'(av); v.art = 16'(art); v.ah = 4'(ah);
    v.cv = 4'(cv); v.cidx = 16'(cidx); v.cval = cval; v.cmp = 4'(cmp);
    v.we = 4'(we); v.data = data; v.rt = 16'(rt); v.ci = 16'(ci);
    v.free = 5'(free); v.head = 4'(head); v.aidx = 16'(aidx);
    v.fl = 1'(fl); v.pc = 16'(pc); v.hlt = 1'(hlt); v.chk = 1'(chk); v.rdy = 16'(rdy);
    return v;
  endfunction

  task automatic check(input string nm, input int r, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h expected %h", nm, r, act, exp);
    end
  endtask

  initial begin
    //              rst av   art     ah   cv   cidx    cval                   cmp  we   data                   rt      ci      free hd aidx    fl pc     hlt chk rdy
    // alloc rt 1..4, then out-of-order writebacks 2,0,1 and commit
    tbl.push_back(row(1, 'hF, 'h4321, 0,   0,   0,      0,                     0,   0,   0,                     0,      0,      16,  0, 'h3210, 0, 0,     0,  1, 0));
    tbl.push_back(row(1, 0,   0,      0,   1,   'h0002, 'h000A,                0,   0,   0,                     0,      0,      12,  0, 'h7654, 0, 0,     0,  0, 0));
    tbl.push_back(row(1, 0,   0,      0,   1,   'h0000, 'h000B,                0,   0,   0,                     0,      0,      12,  0, 'h7654, 0, 0,     0,  0, 0));
    tbl.push_back(row(1, 0,   0,      0,   1,   'h0001, 'h000C,                0,   1,   'h000B,                'h0001, 'h0000, 12,  0, 'h7654, 0, 0,     0,  0, 0));
    tbl.push_back(row(1, 0,   0,      0,   0,   0,      0,                     0,   3,   'h000A_000C,           'h0032, 'h0021, 13,  1, 'h7654, 0, 0,     0,  0, 0));
    tbl.push_back(row(1, 0,   0,      0,   1,   'h0003, 'h0033,                0,   0,   0,                     0,      0,      15,  3, 'h7654, 0, 0,     0,  0, 0));
    tbl.push_back(row(1, 0,   0,      0,   0,   0,      0,                     0,   1,   'h0033,                'h0004, 'h0003, 15,  3, 'h7654, 0, 0,     0,  1, 'h0008));
    // allocate, then reset mid-operation with a pending allocation
    tbl.push_back(row(1, 'hF, 'h4321, 0,   0,   0,      0,                     0,   0,   0,                     0,      0,      16,  4, 'h7654, 0, 0,     0,  0, 0));
    tbl.push_back(row(0, 'hF, 'h4321, 0,   0,   0,      0,                     0,   0,   0,                     0,      0,      12,  4, 'hBA98, 0, 0,     0,  0, 0));
    // fill to full, commit four, re-allocate into the wrapped slots
    tbl.push_back(row(1, 'hF, 'h4321, 0,   0,   0,      0,                     0,   0,   0,                     0,      0,      16,  0, 'h3210, 0, 0,     0,  1, 0));
    tbl.push_back(row(1, 'hF, 'h4321, 0,   0,   0,      0,                     0,   0,   0,                     0,      0,      12,  0, 'h7654, 0, 0,     0,  0, 0));
    tbl.push_back(row(1, 'hF, 'h4321, 0,   0,   0,      0,                     0,   0,   0,                     0,      0,      8,   0, 'hBA98, 0, 0,     0,  0, 0));
    tbl.push_back(row(1, 'hF, 'h4321, 0,   0,   0,      0,                     0,   0,   0,                     0,      0,      4,   0, 'hFEDC, 0, 0,     0,  0, 0));
    tbl.push_back(row(1, 0,   0,      0,   'hF, 'h3210, 'h0103_0102_0101_0100, 0,   0,   0,                     0,      0,      0,   0, 'h3210, 0, 0,     0,  0, 0));
    tbl.push_back(row(1, 0,   0,      0,   0,   0,      0,                     0,   'hF, 'h0103_0102_0101_0100, 'h4321, 'h3210, 0,   0, 'h3210, 0, 0,     0,  1, 'h000F));
    tbl.push_back(row(1, 'hF, 'h4321, 0,   0,   0,      0,                     0,   0,   0,                     0,      0,      4,   4, 'h3210, 0, 0,     0,  0, 0));
    // mispredict at idx6 with duplicate writes to idx5 (lane 0 wins)
    tbl.push_back(row(1, 0,   0,      0,   1,   'h0004, 'h0044,                0,   0,   0,                     0,      0,      0,   4, 'h7654, 0, 0,     0,  0, 0));
    tbl.push_back(row(1, 0,   0,      0,   'hF, 'h5765, 'h0099_0077_0040_0055, 'h2, 1,   'h0044,                'h0001, 'h0004, 0,   4, 'h7654, 0, 0,     0,  0, 0));
    tbl.push_back(row(1, 1,   'h0001, 0,   1,   'h0008, 'h0088,                0,   3,   'h0040_0055,           'h0032, 'h0065, 1,   5, 'h7654, 1, 'h40,  0,  0, 0));
    // halt behind two pending entries
    tbl.push_back(row(1, 'h7, 'h0CBA, 'h4, 0,   0,      0,                     0,   0,   0,                     0,      0,      16,  7, 'hA987, 0, 0,     0,  1, 0));
    tbl.push_back(row(1, 0,   0,      0,   'h3, 'h0087, 'h0080_0070,           0,   0,   0,                     0,      0,      13,  7, 'hDCBA, 0, 0,     0,  0, 0));
    tbl.push_back(row(1, 0,   0,      0,   0,   0,      0,                     0,   3,   'h0080_0070,           'h00BA, 'h0087, 13,  7, 'hDCBA, 0, 0,     0,  1, 'h0380));
    tbl.push_back(row(1, 0,   0,      0,   1,   'h0009, 'h0099,                0,   0,   0,                     0,      0,      15,  9, 'hDCBA, 0, 0,     1,  0, 0));
    tbl.push_back(row(1, 0,   0,      0,   1,   'h000A, 'h00AA,                0,   0,   0,                     0,      0,      15,  9, 'hDCBA, 0, 0,     1,  1, 'h0200));
    tbl.push_back(row(0, 0,   0,      0,   0,   0,      0,                     0,   0,   0,                     0,      0,      15,  9, 'hDCBA, 0, 0,     1,  0, 0));
    tbl.push_back(row(1, 0,   0,      0,   0,   0,      0,                     0,   0,   0,                     0,      0,      16,  0, 'h3210, 0, 0,     0,  1, 0));

    bus.alloc_valid = '0; bus.alloc_rt = '0; bus.alloc_halt = '0;
    bus.cdb_valid = '0; bus.cdb_idx = '0; bus.cdb_value = '0; bus.cdb_mispred = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int r = 0; r < tbl.size(); r++) begin
      rst_n           = tbl[r].rst;
      bus.alloc_valid = tbl[r].av;
      bus.alloc_rt    = tbl[r].art;
      bus.alloc_halt  = tbl[r].ah;
      bus.cdb_valid   = tbl[r].cv;
      bus.cdb_idx     = tbl[r].cidx;
      bus.cdb_value   = tbl[r].cval;
      bus.cdb_mispred = tbl[r].cmp;
      #1;
      check("cmt_we",      r, 64'(bus.cmt_we),      64'(tbl[r].we));
      check("cmt_data",    r, bus.cmt_data,          tbl[r].data);
      check("cmt_rt",      r, 64'(bus.cmt_rt),      64'(tbl[r].rt));
      check("cmt_idx",     r, 64'(bus.cmt_idx),     64'(tbl[r].ci));
      check("free_slots",  r, 64'(bus.free_slots),  64'(tbl[r].free));
      check("head",        r, 64'(bus.head),        64'(tbl[r].head));
      check("alloc_idx",   r, 64'(bus.alloc_idx),   64'(tbl[r].aidx));
      check("flush",       r, 64'(bus.flush),       64'(tbl[r].fl));
      check("redirect_pc", r, 64'(bus.redirect_pc), 64'(tbl[r].pc));
      check("halted",      r, 64'(bus.halted),      64'(tbl[r].hlt));
      if (tbl[r].chk) check("ent_ready", r, 64'(bus.ent_ready), 64'(tbl[r].rdy));
      @(negedge clk);
    end

    // Operand visibility relative to the writeback edge
    bus.alloc_valid = 4'hF; bus.alloc_rt = 16'h4321; bus.alloc_halt = '0;
    bus.cdb_valid = '0; bus.cdb_mispred = '0;
    @(negedge clk);
    bus.alloc_valid = '0;
    bus.cdb_valid = 4'h1; bus.cdb_idx = 16'h0003; bus.cdb_value = 64'h5A5A;
    #1;
    check("byp_rdy", 100, 64'(bus.ent_ready[3]), 64'(BYP));
    check("byp_val", 100, 64'(bus.ent_value[3*16 +: 16]), BYP ? 64'h5A5A : 64'h0);
    check("byp_cmt", 100, 64'(bus.cmt_we), 64'h0);
    @(negedge clk);
    bus.cdb_valid = '0;
    #1;
    check("post_rdy",  101, 64'(bus.ent_ready), 64'h0008);
    check("post_val",  101, 64'(bus.ent_value[3*16 +: 16]), 64'h5A5A);
    check("post_free", 101, 64'(bus.free_slots), 64'd12);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
